// File: rtl/bram_rd_adapter_if.sv
// Request/response and BRAM-port bundle for bram_rd_adapter.
//   master : requester + BRAM side (drives REQ_*, D_OUT, RSP_RDY)
//   slave  : adapter side (drives REQ_RDY, RE, RD_ADDR, RSP_VALID, RSP_DATA)
interface bram_rd_adapter_if #(
  parameter int unsigned addr_width = 1,
  parameter int unsigned data_width = 1
);
  logic                  REQ_VALID;
  logic [addr_width-1:0] REQ_ADDR;
  logic                  REQ_RDY;
  logic                  RE;
  logic [addr_width-1:0] RD_ADDR;
  logic [data_width-1:0] D_OUT;
  logic                  RSP_VALID;
  logic [data_width-1:0] RSP_DATA;
  logic                  RSP_RDY;

  modport master (
    output REQ_VALID, REQ_ADDR, D_OUT, RSP_RDY,
    input  REQ_RDY, RE, RD_ADDR, RSP_VALID, RSP_DATA
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, D_OUT, RSP_RDY,
    output REQ_RDY, RE, RD_ADDR, RSP_VALID, RSP_DATA
  );
endinterface

// File: rtl/bram_rd_adapter.sv
// Bridges a valid/ready read-request stream onto a 1-cycle-latency BRAM read
// port and returns the data, in order, on a valid/ready response stream.
// A 3-entry response FIFO plus one in-flight slot are credited against each
// request, so the BRAM data is always captured the cycle after RE.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : bram_rd_adapter_if.slave (request, BRAM port, response)
module bram_rd_adapter #(
  parameter int unsigned addr_width = 1,
  parameter int unsigned data_width = 1
) (
  input logic              CLK,
  input logic              RST_N,
  bram_rd_adapter_if.slave bus
);

  localparam int unsigned depth = 3;
  localparam int unsigned ptr_w = 2;
  localparam int unsigned cnt_w = 3;

  logic [ptr_w-1:0]      occ;
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic                  inflight;
  logic [data_width-1:0] mem [depth];

  logic accept_c;
  logic wr_c;
  logic rd_c;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign accept_c = bus.REQ_VALID && bus.REQ_RDY;
  assign wr_c     = inflight;
  assign rd_c     = bus.RSP_VALID && bus.RSP_RDY;

  // Credit check uses registered state only, so a same-cycle consume does not
  // free a slot for a same-cycle request.
  assign bus.REQ_RDY   = (cnt_w'(occ) + cnt_w'(inflight)) < cnt_w'(depth);
  assign bus.RE        = accept_c;
  assign bus.RD_ADDR   = bus.REQ_ADDR;
  assign bus.RSP_VALID = (occ != '0);
  assign bus.RSP_DATA  = mem[rd_ptr];

  // Control state: in-flight flag, occupancy and pointers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inflight <= 1'b0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= accept_c;
      if (wr_c) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_c) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_c, rd_c})
        2'b10:   occ <= occ + ptr_w'(1);
        2'b01:   occ <= occ - ptr_w'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Response storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (wr_c) mem[wr_ptr] <= bus.D_OUT;
  end

endmodule
